regfile_port_controller: RTL and testbench
==========================================

Name: regfile_port_controller

Overview:
- Sequencer on the client side of the register block: accepts one register-transfer request (two source ids, one destination id), drives the block's read ports, and latches both operands.
- Presents the operands to the execute stage and waits for a result, then drives the write port for exactly one cycle.
- The register block writes continuously to whatever write_id selects, so this controller parks write_id at 0 (read-only $0) except during the single write cycle.

Parameters:
- WIDTH, 8, data width of register values
- ID_WIDTH, 4, width of register ids
- NUM_REGS, 13, number of implemented registers; ids 0 and >= NUM_REGS are never written

Ports:
- clk  input  1  clock, rising edge
- reset  input  1  asynchronous, active-high reset
- req_valid  input  1  request present
- req_ready  output  1  controller can accept a request
- src1_id  input  ID_WIDTH  first source register
- src2_id  input  ID_WIDTH  second source register
- dst_id  input  ID_WIDTH  destination register
- wb_en  input  1  request performs writeback
- read1_id  output  ID_WIDTH  to register block read port 1
- read2_id  output  ID_WIDTH  to register block read port 2
- read1_value  input  WIDTH  from register block
- read2_value  input  WIDTH  from register block
- write_id  output  ID_WIDTH  to register block write select
- write_value  output  WIDTH  to register block write data
- op_valid  output  1  op_a/op_b valid
- op_ready  input  1  execute stage accepts operands
- op_a  output  WIDTH  latched operand 1
- op_b  output  WIDTH  latched operand 2
- res_valid  input  1  result present (sampled only in WAIT_RES)
- res_value  input  WIDTH  result data
- busy  output  1  high in any state except IDLE
- wr_suppressed  output  1  one-cycle pulse when a writeback targeted id 0 or >= NUM_REGS

Behaviour:
- Reset (async) values:
  - state = IDLE
  - read1_id, read2_id, write_id = 0; write_value = 0
  - op_a, op_b = 0; op_valid = 0; wr_suppressed = 0
  - latched dst/wb_en cleared
- States: IDLE, READ, OPERANDS, WAIT_RES, WR_SETUP, WRITE.
- IDLE:
  - req_ready = 1.
  - On req_valid, latch src1_id, src2_id, dst_id, wb_en; read1_id/read2_id take the src ids on the same edge; go to READ.
- READ (1 cycle): register block outputs settle; at the end of the cycle capture read1_value -> op_a and read2_value -> op_b; go to OPERANDS.
- OPERANDS:
  - op_valid = 1; hold op_a/op_b stable until the handshake.
  - On op_valid && op_ready: go to WAIT_RES if wb_en, otherwise IDLE.
- WAIT_RES:
  - On res_valid, latch res_value into write_value.
  - If dst is 0 or >= NUM_REGS: pulse wr_suppressed for 1 cycle and go to IDLE; write_id stays 0.
  - Otherwise go to WR_SETUP.
- WR_SETUP (1 cycle): write_value is stable, write_id is still 0.
- WRITE (1 cycle): write_id = latched dst; write_value unchanged; go to IDLE.
- Leaving WRITE: write_id returns to 0 on the next edge; write_value holds for that cycle too (data stable one cycle either side of the select).
- Latency:
  - req accept to op_valid: 2 cycles.
  - res_valid to write_id asserted: 2 cycles.
  - Minimum full transaction with zero-wait handshakes: 6 cycles, req_valid to back in IDLE.
- read1_id/read2_id hold their values after READ until the next accepted request; they are never forced to 0.
- Only one request is in flight; req_ready = 0 in every non-IDLE state. req_valid outside IDLE is ignored, not queued.
- res_valid outside WAIT_RES is ignored.
- Simultaneous events:
  - op_ready is honoured in the first OPERANDS cycle.
  - res_valid is honoured in the first WAIT_RES cycle.
- src == dst is legal; operands are captured before the write, so op_a reflects the pre-write value.
- Reset mid-operation:
  - Any state returns to IDLE immediately.
  - write_id drops to 0 asynchronously, so no partial or spurious write occurs.
  - op_valid drops asynchronously.
- busy = (state != IDLE).

Test Plan:
- Reset asserted mid-WRITE (write_id = 5) -> write_id = 0, op_valid = 0, busy = 0 in the same cycle; $5 is not corrupted after reset is released.
- $1 = 0x12, $2 = 0x34 preset; req src1 = 1, src2 = 2, dst = 3, wb_en = 1; op_ready = 1; res_value = 0x46 one cycle after op_valid -> op_a = 0x12, op_b = 0x34 two cycles after accept; write_id = 3 for exactly 1 cycle; $3 reads back 0x46; write_id = 0 in every other cycle.
- Same request with op_ready held low for 4 cycles -> op_valid stays high, op_a/op_b unchanged; write occurs only after res_valid.
- dst = 0 and dst = 14, wb_en = 1, res_value = 0xFF -> wr_suppressed pulses once per request; write_id never leaves 0; $0 still reads 0.
- wb_en = 0 -> controller returns to IDLE on the cycle after the op handshake; no WAIT_RES; a res_valid pulse afterwards has no effect.
- src1 = dst = 9 ($cmp = 0x07), res_value = 0x08 -> op_a = 0x07, then $cmp = 0x08; a second req_valid held during busy is accepted only after return to IDLE.

Source files
------------

// File: rtl/regfile_port_controller.sv
// -----------------------------------------------------------------------------
// regfile_port_controller
//
// Client-side sequencer for a register block with two read ports and one
// continuously-writing write port. It accepts one register-transfer request,
// reads both source registers, and presents the latched operands to an
// execute stage. When writeback is requested, it waits for the result and
// drives the write port for exactly one cycle. At all other times, write_id
// is parked at 0, which is the read-only $0.
//
// Ports
//   clk, reset                  rising-edge clock, async active-high reset
//   req_valid / req_ready       request handshake (accepted only in IDLE)
//   src1_id, src2_id, dst_id    register ids of the request
//   wb_en                       request performs writeback
//   read1_id, read2_id          register block read selects
//   read1_value, read2_value    register block read data
//   write_id, write_value       register block write select / data
//   op_valid / op_ready         operand handshake to execute stage
//   op_a, op_b                  latched operands
//   res_valid, res_value        result from execute stage
//   busy                        controller not in IDLE
//   wr_suppressed               one-cycle pulse: writeback to id 0 or out of range
// -----------------------------------------------------------------------------
module regfile_port_controller #(
    parameter int WIDTH    = 8,
    parameter int ID_WIDTH = 4,
    parameter int NUM_REGS = 13
) (
    input  logic                clk,
    input  logic                reset,
    input  logic                req_valid,
    output logic                req_ready,
    input  logic [ID_WIDTH-1:0] src1_id,
    input  logic [ID_WIDTH-1:0] src2_id,
    input  logic [ID_WIDTH-1:0] dst_id,
    input  logic                wb_en,
    output logic [ID_WIDTH-1:0] read1_id,
    output logic [ID_WIDTH-1:0] read2_id,
    input  logic [WIDTH-1:0]    read1_value,
    input  logic [WIDTH-1:0]    read2_value,
    output logic [ID_WIDTH-1:0] write_id,
    output logic [WIDTH-1:0]    write_value,
    output logic                op_valid,
    input  logic                op_ready,
    output logic [WIDTH-1:0]    op_a,
    output logic [WIDTH-1:0]    op_b,
    input  logic                res_valid,
    input  logic [WIDTH-1:0]    res_value,
    output logic                busy,
    output logic                wr_suppressed
);

    typedef enum logic [2:0] {
        S_IDLE,
        S_READ,
        S_OPERANDS,
        S_WAIT_RES,
        S_WR_SETUP,
        S_WRITE
    } state_t;

    // One extra bit so the comparison stays correct even when NUM_REGS equals 2**ID_WIDTH.
    localparam logic [ID_WIDTH:0] NUM_REGS_EXT = (ID_WIDTH + 1)'(NUM_REGS);

    state_t              state_q, state_d;
    logic [ID_WIDTH-1:0] read1_id_q, read1_id_d;
    logic [ID_WIDTH-1:0] read2_id_q, read2_id_d;
    logic [ID_WIDTH-1:0] dst_q, dst_d;
    logic                wb_en_q, wb_en_d;
    logic [ID_WIDTH-1:0] write_id_q, write_id_d;
    logic [WIDTH-1:0]    write_value_q, write_value_d;
    logic [WIDTH-1:0]    op_a_q, op_a_d;
    logic [WIDTH-1:0]    op_b_q, op_b_d;
    logic                wr_suppressed_q, wr_suppressed_d;
    logic                dst_writable;

    assign dst_writable = (dst_q != '0) && ({1'b0, dst_q} < NUM_REGS_EXT);

    // State register and datapath flops. Because of the async reset, write_id
    // and op_valid (decoded from state) drop as soon as reset rises. A write
    // that is in progress therefore never reaches the register block.
    // NOTE: sequential state uses non-blocking assignments only, so every flop samples pre-edge values.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q         <= S_IDLE;
            read1_id_q      <= '0;
            read2_id_q      <= '0;
            dst_q           <= '0;
            wb_en_q         <= 1'b0;
            write_id_q      <= '0;
            write_value_q   <= '0;
            op_a_q          <= '0;
            op_b_q          <= '0;
            wr_suppressed_q <= 1'b0;
        end else begin
            state_q         <= state_d;
            read1_id_q      <= read1_id_d;
            read2_id_q      <= read2_id_d;
            dst_q           <= dst_d;
            wb_en_q         <= wb_en_d;
            write_id_q      <= write_id_d;
            write_value_q   <= write_value_d;
            op_a_q          <= op_a_d;
            op_b_q          <= op_b_d;
            wr_suppressed_q <= wr_suppressed_d;
        end
    end

    always_comb begin
        // NOTE: every signal assigned here gets a default first, so no path can infer a latch.
        state_d         = state_q;
        read1_id_d      = read1_id_q;
        read2_id_d      = read2_id_q;
        dst_d           = dst_q;
        wb_en_d         = wb_en_q;
        write_value_d   = write_value_q;
        op_a_d          = op_a_q;
        op_b_d          = op_b_q;
        write_id_d      = '0;     // parked on read-only $0 unless entering WRITE
        wr_suppressed_d = 1'b0;   // single-cycle pulse

        unique case (state_q)
            S_IDLE: begin
                if (req_valid) begin
                    read1_id_d = src1_id;
                    read2_id_d = src2_id;
                    dst_d      = dst_id;
                    wb_en_d    = wb_en;
                    state_d    = S_READ;
                end
            end
            S_READ: begin
                // The read selects have been stable for one full cycle, so the block outputs have settled.
                op_a_d  = read1_value;
                op_b_d  = read2_value;
                state_d = S_OPERANDS;
            end
            S_OPERANDS: begin
                if (op_ready) begin
                    state_d = wb_en_q ? S_WAIT_RES : S_IDLE;
                end
            end
            S_WAIT_RES: begin
                if (res_valid) begin
                    write_value_d = res_value;
                    if (dst_writable) begin
                        state_d = S_WR_SETUP;
                    end else begin
                        wr_suppressed_d = 1'b1;
                        state_d         = S_IDLE;
                    end
                end
            end
            S_WR_SETUP: begin
                // write_value has been stable for a cycle; open the select on the next edge.
                write_id_d = dst_q;
                state_d    = S_WRITE;
            end
            S_WRITE: begin
                // write_id_d defaults to 0 and write_value holds, so the data
                // stays stable for one cycle after the select closes.
                state_d = S_IDLE;
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase
    end

    assign req_ready     = (state_q == S_IDLE);
    assign busy          = (state_q != S_IDLE);
    assign op_valid      = (state_q == S_OPERANDS);
    assign read1_id      = read1_id_q;
    assign read2_id      = read2_id_q;
    assign write_id      = write_id_q;
    assign write_value   = write_value_q;
    assign op_a          = op_a_q;
    assign op_b          = op_b_q;
    assign wr_suppressed = wr_suppressed_q;

endmodule

// File: tb/tb_regfile_port_controller.sv
// -----------------------------------------------------------------------------
// tb_regfile_port_controller
//
// Directed and randomized transactions drive the controller. A small
// register-block environment sits behind the controller's read and write
// ports. Expected operands and register contents come from a plain array
// model of the register file, which is updated at the transaction level.
// -----------------------------------------------------------------------------
module tb_regfile_port_controller;

    localparam int WIDTH    = 8;
    localparam int ID_WIDTH = 4;
    localparam int NUM_REGS = 13;

    logic                clk;
    logic                reset;
    logic                req_valid;
    logic                req_ready;
    logic [ID_WIDTH-1:0] src1_id, src2_id, dst_id;
    logic                wb_en;
    logic [ID_WIDTH-1:0] read1_id, read2_id;
    logic [WIDTH-1:0]    read1_value, read2_value;
    logic [ID_WIDTH-1:0] write_id;
    logic [WIDTH-1:0]    write_value;
    logic                op_valid;
    logic                op_ready;
    logic [WIDTH-1:0]    op_a, op_b;
    logic                res_valid;
    logic [WIDTH-1:0]    res_value;
    logic                busy;
    logic                wr_suppressed;

    int n_checks = 0;
    int n_pass   = 0;
    int n_fail   = 0;

    regfile_port_controller #(
        .WIDTH   (WIDTH),
        .ID_WIDTH(ID_WIDTH),
        .NUM_REGS(NUM_REGS)
    ) dut (
        .clk          (clk),
        .reset        (reset),
        .req_valid    (req_valid),
        .req_ready    (req_ready),
        .src1_id      (src1_id),
        .src2_id      (src2_id),
        .dst_id       (dst_id),
        .wb_en        (wb_en),
        .read1_id     (read1_id),
        .read2_id     (read2_id),
        .read1_value  (read1_value),
        .read2_value  (read2_value),
        .write_id     (write_id),
        .write_value  (write_value),
        .op_valid     (op_valid),
        .op_ready     (op_ready),
        .op_a         (op_a),
        .op_b         (op_b),
        .res_valid    (res_valid),
        .res_value    (res_value),
        .busy         (busy),
        .wr_suppressed(wr_suppressed)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Register block environment: $0 is read-only and ids >= NUM_REGS are not
    // implemented. The block writes whatever write_id selects on every edge.
    logic [WIDTH-1:0] env_regs [16] = '{default: '0};
    int               wr_cycles = 0;

    always @(posedge clk) begin
        if (write_id != '0) begin
            wr_cycles <= wr_cycles + 1;
            if (int'(write_id) < NUM_REGS) env_regs[write_id] <= write_value;
        end
    end

    assign read1_value = (int'(read1_id) < NUM_REGS) ? env_regs[read1_id] : '0;
    assign read2_value = (int'(read2_id) < NUM_REGS) ? env_regs[read2_id] : '0;

    // Reference model of the architectural register contents.
    logic [WIDTH-1:0] ref_regs [16];
    logic [WIDTH-1:0] exp_wv     = '0;
    int               exp_writes = 0;

    function automatic logic [WIDTH-1:0] ref_read(input logic [ID_WIDTH-1:0] id);
        return (int'(id) < NUM_REGS) ? ref_regs[id] : '0;
    endfunction

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        assert (obs === exp) n_pass++;
        else begin
            n_fail++;
            $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    // One full transaction, checked cycle by cycle.
    task automatic do_txn(input logic [ID_WIDTH-1:0] s1, input logic [ID_WIDTH-1:0] s2,
                          input logic [ID_WIDTH-1:0] d, input logic wb,
                          input int op_wait, input int res_wait, input logic [WIDTH-1:0] res,
                          input bit hold_req, input bit abort_write);
        logic [WIDTH-1:0] ea, eb;
        bit               writable;
        ea       = ref_read(s1);
        eb       = ref_read(s2);
        writable = (d != '0) && (int'(d) < NUM_REGS);

        check("idle_ready", 32'(req_ready), 32'd1);
        check("idle_busy", 32'(busy), 32'd0);
        src1_id = s1; src2_id = s2; dst_id = d; wb_en = wb; req_valid = 1'b1;
        step();
        if (hold_req) begin
            // Request stays asserted with different fields; it must be ignored while busy.
            src1_id = 4'hA; src2_id = 4'hB; dst_id = 4'hC; wb_en = ~wb;
        end else begin
            req_valid = 1'b0;
        end

        // READ
        check("read_busy", 32'(busy), 32'd1);
        check("read_req_ready", 32'(req_ready), 32'd0);
        check("read_op_valid", 32'(op_valid), 32'd0);
        check("read1_id", 32'(read1_id), 32'(s1));
        check("read2_id", 32'(read2_id), 32'(s2));
        check("read_write_id", 32'(write_id), 32'd0);
        step();

        // OPERANDS: op_valid two cycles after accept
        check("op_valid", 32'(op_valid), 32'd1);
        check("op_a", 32'(op_a), 32'(ea));
        check("op_b", 32'(op_b), 32'(eb));
        for (int i = 0; i < op_wait; i++) begin
            op_ready  = 1'b0;
            res_valid = 1'($urandom_range(1, 0));  // ignored outside WAIT_RES
            res_value = WIDTH'($urandom);
            step();
            check("op_hold_valid", 32'(op_valid), 32'd1);
            check("op_hold_a", 32'(op_a), 32'(ea));
            check("op_hold_b", 32'(op_b), 32'(eb));
            check("op_hold_write_id", 32'(write_id), 32'd0);
        end
        op_ready  = 1'b1;
        res_valid = 1'b0;
        step();
        op_ready = 1'b0;
        if (hold_req) check("held_read1_id", 32'(read1_id), 32'(s1));

        if (!wb) begin
            check("nowb_idle", 32'(busy), 32'd0);
            check("nowb_op_valid", 32'(op_valid), 32'd0);
            res_valid = 1'b1;
            res_value = 8'hEE;
            step();
            res_valid = 1'b0;
            check("stray_res_busy", 32'(busy), 32'd0);
            check("stray_res_supp", 32'(wr_suppressed), 32'd0);
            check("stray_res_write_id", 32'(write_id), 32'd0);
            check("stray_res_wv", 32'(write_value), 32'(exp_wv));
        end else begin
            check("wait_busy", 32'(busy), 32'd1);
            check("wait_op_valid", 32'(op_valid), 32'd0);
            for (int i = 0; i < res_wait; i++) begin
                res_valid = 1'b0;
                step();
                check("wait_write_id", 32'(write_id), 32'd0);
                check("wait_still_busy", 32'(busy), 32'd1);
            end
            res_valid = 1'b1;
            res_value = res;
            step();
            res_valid = 1'b0;
            res_value = WIDTH'($urandom);
            exp_wv    = res;
            if (!writable) begin
                check("supp_pulse", 32'(wr_suppressed), 32'd1);
                check("supp_idle", 32'(busy), 32'd0);
                check("supp_write_id", 32'(write_id), 32'd0);
                check("supp_wv", 32'(write_value), 32'(res));
                step();
                check("supp_pulse_end", 32'(wr_suppressed), 32'd0);
                check("supp_write_id2", 32'(write_id), 32'd0);
            end else begin
                // WR_SETUP
                check("setup_write_id", 32'(write_id), 32'd0);
                check("setup_wv", 32'(write_value), 32'(res));
                check("setup_supp", 32'(wr_suppressed), 32'd0);
                step();
                // WRITE
                check("write_id", 32'(write_id), 32'(d));
                check("write_wv", 32'(write_value), 32'(res));
                if (abort_write) begin
                    reset = 1'b1;
                    #1;
                    check("abort_write_id", 32'(write_id), 32'd0);
                    check("abort_op_valid", 32'(op_valid), 32'd0);
                    check("abort_busy", 32'(busy), 32'd0);
                    exp_wv = '0;
                    step();
                    reset = 1'b0;
                end else begin
                    step();
                    check("post_write_id", 32'(write_id), 32'd0);
                    check("post_write_wv", 32'(write_value), 32'(res));
                    check("post_write_idle", 32'(busy), 32'd0);
                    ref_regs[d] = res;
                    exp_writes++;
                end
            end
        end
        if (hold_req) check("held_req_ready", 32'(req_ready), 32'd1);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not complete");
        $fatal(1, "watchdog");
    end

    initial begin
        for (int i = 0; i < 16; i++) ref_regs[i] = '0;
        reset = 1'b0; req_valid = 1'b0; src1_id = '0; src2_id = '0; dst_id = '0;
        wb_en = 1'b0; op_ready = 1'b0; res_valid = 1'b0; res_value = '0;

        // Reset values
        #2 reset = 1'b1;
        #2;
        check("rst_req_ready", 32'(req_ready), 32'd1);
        check("rst_busy", 32'(busy), 32'd0);
        check("rst_read1_id", 32'(read1_id), 32'd0);
        check("rst_read2_id", 32'(read2_id), 32'd0);
        check("rst_write_id", 32'(write_id), 32'd0);
        check("rst_write_value", 32'(write_value), 32'd0);
        check("rst_op_a", 32'(op_a), 32'd0);
        check("rst_op_b", 32'(op_b), 32'd0);
        check("rst_op_valid", 32'(op_valid), 32'd0);
        check("rst_wr_supp", 32'(wr_suppressed), 32'd0);
        step();
        step();
        reset = 1'b0;
        step();

        // Preset $1 = 0x12, $2 = 0x34, then the basic transfer into $3
        do_txn(4'd0, 4'd0, 4'd1, 1'b1, 0, 0, 8'h12, 1'b0, 1'b0);
        do_txn(4'd0, 4'd0, 4'd2, 1'b1, 0, 0, 8'h34, 1'b0, 1'b0);
        do_txn(4'd1, 4'd2, 4'd3, 1'b1, 0, 0, 8'h46, 1'b0, 1'b0);
        // Same request with op_ready held low for 4 cycles and a delayed result
        do_txn(4'd1, 4'd2, 4'd3, 1'b1, 4, 2, 8'h46, 1'b0, 1'b0);
        // Suppressed writebacks to $0 and to an unimplemented id
        do_txn(4'd1, 4'd2, 4'd0, 1'b1, 0, 0, 8'hFF, 1'b0, 1'b0);
        do_txn(4'd1, 4'd2, 4'd14, 1'b1, 0, 1, 8'hFF, 1'b0, 1'b0);
        // No writeback: back to IDLE right after the op handshake
        do_txn(4'd3, 4'd1, 4'd3, 1'b0, 1, 0, 8'h00, 1'b0, 1'b0);
        // src == dst: operand reflects the pre-write value; the request held during busy
        do_txn(4'd0, 4'd0, 4'd9, 1'b1, 0, 0, 8'h07, 1'b0, 1'b0);
        do_txn(4'd9, 4'd1, 4'd9, 1'b1, 0, 0, 8'h08, 1'b1, 1'b0);
        do_txn(4'd9, 4'd9, 4'd0, 1'b0, 0, 0, 8'h00, 1'b0, 1'b0);
        // Reset during WRITE to $5: $5 keeps 0x55
        do_txn(4'd0, 4'd0, 4'd5, 1'b1, 0, 0, 8'h55, 1'b0, 1'b0);
        do_txn(4'd1, 4'd2, 4'd5, 1'b1, 0, 0, 8'hAA, 1'b0, 1'b1);
        do_txn(4'd5, 4'd0, 4'd0, 1'b0, 0, 0, 8'h00, 1'b0, 1'b0);

        // Randomized transactions
        for (int n = 0; n < 40; n++) begin
            do_txn(ID_WIDTH'($urandom_range(15, 0)), ID_WIDTH'($urandom_range(15, 0)),
                   ID_WIDTH'($urandom_range(15, 0)), 1'($urandom_range(1, 0)),
                   int'($urandom_range(3, 0)), int'($urandom_range(3, 0)),
                   WIDTH'($urandom), 1'b0, 1'b0);
        end

        // Final register contents and write-cycle count
        for (int i = 0; i < 16; i++) begin
            check($sformatf("final_reg_%0d", i), 32'(env_regs[i]), 32'(ref_regs[i]));
        end
        check("write_cycles", 32'(wr_cycles), 32'(exp_writes));

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
